// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: flag bit positions, condition codes
// and the resolver state encoding.
package branch_pkg;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_P = 0;

  typedef enum logic [2:0] {
    COND_NZ = 3'b000,
    COND_Z  = 3'b001,
    COND_NC = 3'b010,
    COND_C  = 3'b011,
    COND_P  = 3'b100,
    COND_M  = 3'b101,
    COND_PO = 3'b110,
    COND_PE = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/branch_flag_resolver_if.sv
// Stage-3 control/flag bus between control generation and the branch resolver.
interface branch_flag_resolver_if #(
  parameter int ADDR_W = 8
);
  logic              valid;
  logic              efl;
  logic              s_al;
  logic              lpc;
  logic [2:0]        cond;
  logic [3:0]        alu_flags;
  logic [ADDR_W-1:0] target;
  logic [3:0]        flags_q;
  logic              load_pc;
  logic [ADDR_W-1:0] pc_out;
  logic              flush;
  logic              busy;

  modport master (
    output valid, efl, s_al, lpc, cond, alu_flags, target,
    input  flags_q, load_pc, pc_out, flush, busy
  );

  modport slave (
    input  valid, efl, s_al, lpc, cond, alu_flags, target,
    output flags_q, load_pc, pc_out, flush, busy
  );
endinterface

// File: rtl/branch_flag_resolver_cond_eval.sv
// Combinational condition evaluator: maps a 3-bit condition code and {S,Z,C,P}
// flags to a true/false result.
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_NZ: cond_true = ~flags[FLAG_Z];
      COND_Z:  cond_true =  flags[FLAG_Z];
      COND_NC: cond_true = ~flags[FLAG_C];
      COND_C:  cond_true =  flags[FLAG_C];
      COND_P:  cond_true = ~flags[FLAG_S];
      COND_M:  cond_true =  flags[FLAG_S];
      COND_PO: cond_true = ~flags[FLAG_P];
      COND_PE: cond_true =  flags[FLAG_P];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_resolver.sv
// Stage-3 branch resolver: owns the flag register, decides taken transfers,
// issues a registered PC load and holds flush for FLUSH_CYCLES cycles.
module branch_flag_resolver
  import branch_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_flag_resolver_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        flags_q, flags_d;
  logic              load_pc_q, load_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;

  logic cond_true;
  logic accept;
  logic taken;

  // Condition is evaluated on the registered flags: no forwarding of alu_flags.
  cond_eval u_cond_eval (
    .cond      (bus.cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign accept = bus.valid && (state_q == ST_IDLE);
  assign taken  = accept && bus.lpc && (!bus.efl || cond_true);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    load_pc_d = 1'b0;
    pc_d      = pc_q;
    flush_d   = flush_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.s_al) flags_d = bus.alu_flags;
        if (taken) begin
          state_d   = ST_FLUSH;
          cnt_d     = 4'(FLUSH_CYCLES - 1);
          load_pc_d = 1'b1;
          pc_d      = bus.target;
          flush_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      flags_q   <= '0;
      load_pc_q <= 1'b0;
      pc_q      <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      load_pc_q <= load_pc_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.flags_q = flags_q;
  assign bus.load_pc = load_pc_q;
  assign bus.pc_out  = pc_q;
  assign bus.flush   = flush_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_branch_flag_resolver.sv
// Scoreboard bench for branch_flag_resolver: directed scenarios, a full
// condition/flag sweep and random traffic against a cycle-level reference model.
module tb_branch_flag_resolver;

  localparam int ADDR_W = 8;
  localparam int FC     = 2;

  typedef struct {
    logic [3:0]        flags;
    logic              load;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model state: "rem" is the number of flush cycles still to show.
  logic [3:0]        m_flags = '0;
  logic              m_load  = 1'b0;
  logic [ADDR_W-1:0] m_pc    = '0;
  int                m_rem   = 0;

  branch_flag_resolver_if #(.ADDR_W(ADDR_W)) bus ();

  branch_flag_resolver #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit cond_holds(logic [2:0] c, logic [3:0] f);
    int idx_tbl [4] = '{2, 1, 3, 0};  // Z, C, S, P selected by c[2:1]
    return f[idx_tbl[c[2:1]]] == c[0];
  endfunction

  task automatic drive(input bit r, input bit v, input bit e, input bit s,
                       input bit l, input logic [2:0] c, input logic [3:0] f,
                       input logic [ADDR_W-1:0] t);
    exp_t x;
    @(negedge clk);
    rst = r; bus.valid = v; bus.efl = e; bus.s_al = s; bus.lpc = l;
    bus.cond = c; bus.alu_flags = f; bus.target = t;
    if (r) begin
      m_flags = '0; m_load = 1'b0; m_pc = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_load = 1'b0;
      m_rem  = m_rem - 1;
    end else begin
      m_load = 1'b0;
      if (v && l && (!e || cond_holds(c, m_flags))) begin
        m_load = 1'b1;
        m_pc   = t;
        m_rem  = FC;
      end
      if (v && s) m_flags = f;
    end
    x.flags = m_flags; x.load = m_load; x.pc = m_pc;
    x.flush = (m_rem > 0); x.busy = (m_rem > 0);
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 3'd0, 4'd0, 8'h00);
  endtask

  // Monitor: outputs are registered, so every cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 5;
        if (bus.flags_q !== e.flags) begin
          errors++; $display("FAIL flags_q got %h exp %h at %0t", bus.flags_q, e.flags, $time);
        end
        if (bus.load_pc !== e.load) begin
          errors++; $display("FAIL load_pc got %b exp %b at %0t", bus.load_pc, e.load, $time);
        end
        if (bus.pc_out !== e.pc) begin
          errors++; $display("FAIL pc_out got %h exp %h at %0t", bus.pc_out, e.pc, $time);
        end
        if (bus.flush !== e.flush) begin
          errors++; $display("FAIL flush got %b exp %b at %0t", bus.flush, e.flush, $time);
        end
        if (bus.busy !== e.busy) begin
          errors++; $display("FAIL busy got %b exp %b at %0t", bus.busy, e.busy, $time);
        end
      end
    end
  end

  initial begin
    int waited;
    bus.valid = 0; bus.efl = 0; bus.s_al = 0; bus.lpc = 0;
    bus.cond = '0; bus.alu_flags = '0; bus.target = '0;

    drive(1, 1, 1, 1, 1, 3'd1, 4'hF, 8'hFF);
    drive(1, 0, 0, 0, 0, 3'd0, 4'd0, 8'h00);
    idle(2);

    // Flag load then Z branch
    drive(0, 1, 0, 1, 0, 3'd0, 4'b0100, 8'h00);
    drive(0, 1, 1, 0, 1, 3'b001, 4'd0, 8'h3C);
    idle(4);

    // Not taken on C with flags cleared
    drive(0, 1, 0, 1, 0, 3'd0, 4'b0000, 8'h00);
    drive(0, 1, 1, 0, 1, 3'b011, 4'd0, 8'h77);
    idle(2);

    // Squash window: flag writes and jumps during flush are ignored
    drive(0, 1, 0, 0, 1, 3'd0, 4'd0, 8'h5A);
    drive(0, 1, 0, 1, 1, 3'd0, 4'hF, 8'h10);
    drive(0, 1, 0, 1, 1, 3'd0, 4'hF, 8'h10);
    idle(2);

    // Simultaneous flag update and conditional on the old Z
    drive(0, 1, 0, 1, 0, 3'd0, 4'b0000, 8'h00);
    drive(0, 1, 1, 1, 1, 3'b001, 4'b0100, 8'h99);
    idle(2);

    // Unconditional jump, reset during first flush cycle, jump right after
    drive(0, 1, 0, 0, 1, 3'd0, 4'd0, 8'hA5);
    drive(1, 0, 0, 0, 0, 3'd0, 4'd0, 8'h00);
    drive(0, 1, 0, 0, 1, 3'd0, 4'd0, 8'h42);
    idle(3);

    // Sweep every condition against every flag value
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(0, 1, 0, 1, 0, 3'd0, 4'(f), 8'h00);
        drive(0, 1, 1, 0, 1, 3'(c), 4'd0, 8'(c * 16 + f));
        idle(2);
      end
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 4'($urandom), 8'($urandom));
    end
    idle(2);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_flag_resolver.md
Name: branch_flag_resolver

Overview:
- Stage-3 consumer of the stage-3 control code: takes EFL / S_AL / LPC plus ALU flags, the condition field and the branch target.
- Owns the architectural flag register and evaluates conditional jump / call / return conditions.
- Issues the registered PC-load, and squashes younger pipeline stages for a fixed flush window.
- Sits between stage-3 control generation and the PC / fetch logic.

Parameters:
- ADDR_W, 8, width of PC / branch target.
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  stage-3 instruction slot holds a real instruction.
- efl  input  1  evaluate flags (conditional control transfer).
- s_al  input  1  ALU result selected; flags must be updated.
- lpc  input  1  instruction may load PC.
- cond  input  3  condition field, opcode[2:0].
- alu_flags  input  4  {S,Z,C,P} produced by the ALU this cycle.
- target  input  ADDR_W  branch / call / return destination.
- flags_q  output  4  architectural flag register {S,Z,C,P}.
- load_pc  output  1  one-cycle pulse: PC <= pc_out.
- pc_out  output  ADDR_W  registered target; held until the next taken transfer.
- flush  output  1  squash stages 1-2; high for FLUSH_CYCLES cycles.
- busy  output  1  high while in the FLUSH state.

Behaviour:
Reset (rst=1 at posedge):
- flags_q=0, load_pc=0, pc_out=0, flush=0, busy=0, state=IDLE, flush counter=0.
- Reset overrides everything, including reset mid-flush: the block is in IDLE the next cycle.

States:
- IDLE: accepts instructions.
- FLUSH: squashing; counter counts down.

Accepted instruction:
- Defined as valid=1 with state==IDLE.
- When state==FLUSH, all inputs are ignored: no flag update and no branch.

Flag update:
- Accepted with s_al=1: flags_q <= alu_flags at the posedge.
- Visible the next cycle.

Condition evaluation (against the current flags_q):
- 000 NZ (Z=0), 001 Z (Z=1), 010 NC (C=0), 011 C (C=1).
- 100 P (S=0), 101 M (S=1), 110 PO (P=0), 111 PE (P=1).

Transfer decision:
- Taken if an accepted instruction has lpc=1 and either efl=0 (unconditional) or efl=1 with the condition true.
- lpc=0: never taken; efl is ignored.

Taken transfer, from posedge N:
- Cycle N+1: load_pc=1, pc_out=target, flush=1, busy=1, state=FLUSH, counter=FLUSH_CYCLES-1.
- Each following cycle in FLUSH: load_pc=0, flush stays 1.
- When counter==0, return to IDLE at the next posedge: flush=0, busy=0.
- Total flush-high cycles = FLUSH_CYCLES exactly.

Not-taken conditional:
- No outputs change except flags_q, if s_al is also set.

Simultaneous s_al and lpc:
- Flags are updated and the condition is evaluated on the OLD flags_q.
- No same-cycle forwarding.

Other rules:
- Back-to-back taken branches are impossible: the second instruction is inside the flush window and squashed.
- pc_out holds its last value when not loading.
- load_pc is never high for two consecutive cycles.

Decomposition:
- Shared package (branch_pkg): flag bit indices (S=3, Z=2, C=1, P=0), 3-bit condition code constants (NZ, Z, NC, C, P, M, PO, PE), state enum {IDLE, FLUSH}.
- One natural sub-module: cond_eval, a combinational map of (cond, flags) to true/false, reusable by the stage-2 predictor.
- The sequential FSM, flag register and counter stay in branch_flag_resolver.

Test Plan:
- Flag load then Z branch:
  - Stimulus: s_al with alu_flags=4'b0100, then next cycle efl=lpc=1, cond=001, target=8'h3C.
  - Expected: flags_q=4'b0100, load_pc pulse one cycle, pc_out=8'h3C, flush high exactly 2 cycles.
- Not taken:
  - Stimulus: flags_q=0, efl=lpc=1, cond=011 (C).
  - Expected: load_pc stays 0, flush stays 0, pc_out unchanged.
- Squash window:
  - Stimulus: taken branch, then on each of the following 2 cycles present s_al with alu_flags=4'hF and a second taken jump to 8'h10.
  - Expected: flags_q unchanged, pc_out keeps the first target, no second load_pc.
- Simultaneous update:
  - Stimulus: flags_q=0; one instruction with s_al=efl=lpc=1, cond=001, alu_flags=4'b0100.
  - Expected: branch not taken (old Z=0), flags_q=4'b0100 next cycle.
- Unconditional and reset:
  - Stimulus: efl=0, lpc=1, target=8'hA5; assert rst during the first flush cycle.
  - Expected: load_pc and flush first, then all outputs 0 and busy=0 the cycle after rst; a new jump is accepted immediately after rst drops.
- Sweep all 8 cond codes × 16 flag values:
  - Expected: taken exactly per the condition table.
